// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FSM states, bubble encoding and instruction size.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_LAST,
    S_HOLD
  } state_t;

  localparam logic [31:0] NOP_BUBBLE = 32'h0;
  localparam int unsigned INSN_BYTES = 4;
  localparam logic [1:0]  K_LAST     = 2'(INSN_BYTES - 1);

endpackage

// File: rtl/if_byte_asm.sv
// Byte assembler: counts granted bytes and shifts the returning
// byte stream into a little-endian 32-bit instruction word.
module if_byte_asm
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  din,
  output logic [1:0]  k,
  output logic [31:0] word
);

  logic        pend;
  logic [31:0] sbuf;

  // Byte k lands in the top lane and drifts down as later bytes arrive,
  // so after four captures byte 0 sits in [7:0].
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      k    <= '0;
      pend <= 1'b0;
      sbuf <= NOP_BUBBLE;
    end else begin
      pend <= take;
      if (take) k <= k + 2'd1;
      if (pend) sbuf <= {din, sbuf[31:8]};
    end
  end

  assign word = pend ? {din, sbuf[31:8]} : sbuf;

endmodule

// File: rtl/if_fetch.sv
// IF stage: byte-serial instruction fetch feeding decode.
// Define IF_PREFETCH_EN for a one-entry prefetch buffer.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redir,
  input  logic [XLEN-1:0] redir_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_a,
  input  logic            mem_gnt,
  input  logic [7:0]      mem_din,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] is
);

  state_t          state, state_nx;
  logic [XLEN-1:0] fa, fa_nx, fa_inc;
  logic [XLEN-1:0] pc_nx, is_nx;
  logic [1:0]      k;
  logic [31:0]     word;
  logic            take, done;

`ifdef IF_PREFETCH_EN
  logic            pb_valid, pb_valid_nx;
  logic [XLEN-1:0] pb_pc, pb_pc_nx;
  logic [XLEN-1:0] pb_is, pb_is_nx;
`endif

  assign mem_req = rst_n & (state == S_REQ);
  assign mem_a   = fa + XLEN'(k);
  assign fa_inc  = fa + XLEN'(INSN_BYTES);
  assign take    = mem_req & mem_gnt & ~redir;
  assign done    = (state == S_LAST) || (state == S_HOLD);

  if_byte_asm u_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redir),
    .take  (take),
    .din   (mem_din),
    .k     (k),
    .word  (word)
  );

  always_comb begin
    state_nx = state;
    fa_nx    = fa;
    pc_nx    = pc;
    is_nx    = is;
`ifdef IF_PREFETCH_EN
    pb_valid_nx = pb_valid;
    pb_pc_nx    = pb_pc;
    pb_is_nx    = pb_is;
`endif

    unique case (state)
      S_REQ:  if (take && k == K_LAST) state_nx = S_LAST;
      S_LAST: state_nx = S_LAST;
      S_HOLD: state_nx = S_HOLD;
      default: state_nx = S_REQ;
    endcase

`ifdef IF_PREFETCH_EN
    if (!stall) begin
      is_nx = NOP_BUBBLE;
      if (pb_valid) begin
        pc_nx       = pb_pc;
        is_nx       = pb_is;
        pb_valid_nx = 1'b0;
      end
      if (done) begin
        // Buffered word goes out first; the fresh one takes its slot.
        if (pb_valid) begin
          pb_valid_nx = 1'b1;
          pb_pc_nx    = fa_inc;
          pb_is_nx    = XLEN'(word);
        end else begin
          pc_nx = fa_inc;
          is_nx = XLEN'(word);
        end
        fa_nx    = fa_inc;
        state_nx = S_REQ;
      end
    end else if (done) begin
      if (!pb_valid) begin
        pb_valid_nx = 1'b1;
        pb_pc_nx    = fa_inc;
        pb_is_nx    = XLEN'(word);
        fa_nx       = fa_inc;
        state_nx    = S_REQ;
      end else begin
        state_nx = S_HOLD;
      end
    end
`else
    if (!stall) begin
      is_nx = NOP_BUBBLE;
      if (done) begin
        pc_nx    = fa_inc;
        is_nx    = XLEN'(word);
        fa_nx    = fa_inc;
        state_nx = S_REQ;
      end
    end else if (done) begin
      state_nx = S_HOLD;
    end
`endif

    // Wrong-path work never survives a redirect, even under stall.
    if (redir) begin
      fa_nx    = {redir_pc[XLEN-1:2], 2'b00};
      state_nx = S_REQ;
      is_nx    = NOP_BUBBLE;
`ifdef IF_PREFETCH_EN
      pb_valid_nx = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_REQ;
      fa    <= RESET_PC;
      pc    <= '0;
      is    <= NOP_BUBBLE;
    end else begin
      state <= state_nx;
      fa    <= fa_nx;
      pc    <= pc_nx;
      is    <= is_nx;
    end
  end

`ifdef IF_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pb_valid <= 1'b0;
      pb_pc    <= '0;
      pb_is    <= NOP_BUBBLE;
    end else begin
      pb_valid <= pb_valid_nx;
      pb_pc    <= pb_pc_nx;
      pb_is    <= pb_is_nx;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory model, word scoreboard,
// directed latency/stall/redirect/reset cases plus random grant.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic        mem_req;
  logic [31:0] mem_a;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic [31:0] pc;
  logic [31:0] is;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] is;
  } exp_t;

  exp_t        wq[$];
  logic [31:0] ea;
  logic        fresh = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  int          nwords = 0;

`ifdef IF_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  if_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .redir    (redir),
    .redir_pc (redir_pc),
    .mem_req  (mem_req),
    .mem_a    (mem_a),
    .mem_gnt  (mem_gnt),
    .mem_din  (mem_din),
    .pc       (pc),
    .is       (is)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] ww(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic [31:0] a);
    exp_t e;
    ea = a;
    wq.delete();
    for (int i = 0; i < 40; i++) begin
      e.pc = a + 32'(4 * (i + 1));
      e.is = ww(a + 32'(4 * i));
      wq.push_back(e);
    end
  endtask

  task automatic wait_word(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      tick();
      if (fresh && is != 0) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  always @(posedge clk) begin
    mem_din <= (mem_req && mem_gnt) ? mb(mem_a) : 8'hEE;
    fresh   <= rst_n && !stall && !redir;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_req && mem_gnt) begin
        check("sb_addr", mem_a, ea);
        ea = ea + 32'd1;
      end
      if (fresh && is != 0) begin
        nwords++;
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("sb_pc", pc, e.pc);
          check("sb_is", is, e.is);
        end else begin
          check("sb_extra", is, 32'h0);
        end
      end
    end
  end

  initial begin
    int n0;
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0;
    redir_pc = '0; mem_gnt = 1'b1;
    ea = '0;
    repeat (2) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_is", is, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);

    // first word, continuous grant
    rst_n = 1'b1;
    seg(32'h0);
    check("a0", mem_a, 32'h0);
    repeat (4) tick();
    check("lat4_bubble", is, 32'h0);
    tick();
    check("w0_is", is, 32'h0010_0513);
    check("w0_pc", pc, 32'h4);
    check("w1_a", mem_a, 32'h4);

    // grant withheld three cycles on byte 2
    repeat (2) tick();
    mem_gnt = 1'b0;
    check("gnt_hold_a", mem_a, 32'h6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gnt_hold_a", mem_a, 32'h6);
    end
    mem_gnt = 1'b1;
    repeat (2) tick();
    check("gnt_late_bubble", is, 32'h0);
    tick();
    check("gnt_w_is", is, ww(32'h4));
    check("gnt_w_pc", pc, 32'h8);

    // completion under a 4-cycle stall
    repeat (2) tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_is", is, 32'h0);
      check("stall_pc", pc, 32'h8);
      if (i == 2) begin
        check("stall_req", {31'b0, mem_req}, {31'b0, PF});
        if (PF) check("pf_a", mem_a, 32'hC);
      end
    end
    stall = 1'b0;
    tick();
    check("unstall_is", is, ww(32'h8));
    check("unstall_pc", pc, 32'hC);
    stall = 1'b1;
    repeat (2) tick();
    check("hold_is", is, ww(32'h8));
    check("hold_pc", pc, 32'hC);
    stall = 1'b0;
    wait_word("wait_w3", 20);
    check("w3_is", is, ww(32'hC));
    check("w3_pc", pc, 32'h10);

    // redirect while fetching byte 1
    tick();
    redir = 1'b1; redir_pc = 32'h0000_1002;
    check("rd_byte1_a", mem_a, 32'h11);
    tick();
    redir = 1'b0;
    seg(32'h1000);
    check("rd_bubble", is, 32'h0);
    check("rd_a", mem_a, 32'h1000);
    repeat (4) tick();
    check("rd_lat_bubble", is, 32'h0);
    tick();
    check("rd_w_is", is, ww(32'h1000));
    check("rd_w_pc", pc, 32'h1004);

    // redirect coincident with a stalled completion
    stall = 1'b1;
    repeat (4) tick();
    check("rdst_hold_is", is, ww(32'h1000));
    redir = 1'b1; redir_pc = 32'h0000_2000;
    tick();
    redir = 1'b0; stall = 1'b0;
    seg(32'h2000);
    check("rdst_bubble", is, 32'h0);
    check("rdst_a", mem_a, 32'h2000);
    wait_word("wait_rdst", 20);
    check("rdst_w_pc", pc, 32'h2004);
    check("rdst_w_is", is, ww(32'h2000));

    // back-to-back redirects
    redir = 1'b1; redir_pc = 32'h0000_3000;
    tick();
    seg(32'h3000);
    redir_pc = 32'h0000_4001;
    check("b2b_a1", mem_a, 32'h3000);
    tick();
    redir = 1'b0;
    seg(32'h4000);
    check("b2b_a2", mem_a, 32'h4000);
    wait_word("wait_b2b", 20);
    check("b2b_pc", pc, 32'h4004);
    check("b2b_is", is, ww(32'h4000));

    // address wrap at the top of memory
    redir = 1'b1; redir_pc = 32'hFFFF_FFFE;
    tick();
    redir = 1'b0;
    seg(32'hFFFF_FFFC);
    check("wrap_start_a", mem_a, 32'hFFFF_FFFC);
    wait_word("wait_wrap", 20);
    check("wrap_pc", pc, 32'h0);
    check("wrap_is", is, ww(32'hFFFF_FFFC));
    check("wrap_next_a", mem_a, 32'h0);
    wait_word("wait_wrap2", 20);
    check("wrap2_is", is, 32'h0010_0513);

    // reset mid-fetch
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("mrst_pc", pc, 32'h0);
    check("mrst_is", is, 32'h0);
    check("mrst_req", {31'b0, mem_req}, 32'h0);
    rst_n = 1'b1;
    seg(32'h0);
    check("mrst_a", mem_a, 32'h0);
    wait_word("wait_mrst", 10);
    check("mrst_w_pc", pc, 32'h4);
    check("mrst_w_is", is, 32'h0010_0513);

    // random grant and stall traffic
    n0 = nwords;
    for (int i = 0; i < 150; i++) begin
      mem_gnt = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      tick();
    end
    mem_gnt = 1'b1; stall = 1'b0;
    repeat (12) tick();
    check("rand_progress", {31'b0, (nwords - n0) > 4}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
